// File: rtl/demux_1x16_buf_pkg.sv
// Shared defaults and decode types for the buffered 1-to-N bus demultiplexer.
package demux_1x16_buf_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_N     = 16;
    localparam int DEMUX_SEL_W = 4;

    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_ONE,
        LOAD_ALL
    } load_mode_e;

endpackage

// File: rtl/demux_1x16_buf_slot.sv
// One destination holding slot: a data register plus a valid flag.
module demux_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Load wins over ack so a same-cycle ack+load keeps the slot full.
    always_comb begin
        valid_d = load_i | (valid_q & ~ack_i);
        data_d  = load_i ? d_i : data_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q_o     = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_1x16_buf.sv
// Buffered 1-to-N bus demultiplexer with per-slot ack.
// Optional broadcast delivery to all slots is built when DEMUX_BCAST_EN is defined.
module demux_1x16_buf
    import demux_1x16_buf_pkg::*;
#(
    parameter  int WIDTH = DEMUX_WIDTH,
    parameter  int N     = DEMUX_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ack,
    output logic [SEL_W:0]     out_count,
    input  logic               in_bcast
);

    logic [N-1:0]   slot_free;
    logic [N-1:0]   sel_onehot;
    logic [N-1:0]   load;
    logic [N-1:0]   valid_d;
    logic           sel_ok;
    logic           single_ready;
    load_mode_e     mode;
    logic [SEL_W:0] count_q, count_d;

    assign slot_free = ~out_valid | out_ack;
    assign sel_ok    = ({1'b0, in_sel} < (SEL_W+1)'(N));

    always_comb begin
        sel_onehot = '0;
        if (sel_ok) begin
            sel_onehot[in_sel] = 1'b1;
        end
    end

    // Reduction over the one-hot avoids indexing past N for non-power-of-2 N.
    assign single_ready = |(sel_onehot & slot_free);

`ifdef DEMUX_BCAST_EN
    always_comb begin
        mode     = LOAD_NONE;
        in_ready = in_bcast ? (&slot_free) : single_ready;
        if (in_valid && in_ready) begin
            mode = in_bcast ? LOAD_ALL : LOAD_ONE;
        end
    end
`else
    logic unused_bcast;
    assign unused_bcast = in_bcast;

    always_comb begin
        mode     = LOAD_NONE;
        in_ready = single_ready;
        if (in_valid && in_ready) begin
            mode = LOAD_ONE;
        end
    end
`endif

    always_comb begin
        case (mode)
            LOAD_ONE: load = sel_onehot;
            LOAD_ALL: load = '1;
            default:  load = '0;
        endcase
    end

    // Count tracks the next-state valid vector so it always equals popcount(out_valid).
    always_comb begin
        valid_d = load | (out_valid & ~out_ack);
        count_d = '0;
        for (int unsigned k = 0; k < N; k++) begin
            count_d = count_d + (SEL_W+1)'(valid_d[k]);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .clr     (clr),
            .load_i  (load[k]),
            .ack_i   (out_ack[k]),
            .d_i     (in_data),
            .q_o     (out_data[k*WIDTH +: WIDTH]),
            .valid_o (out_valid[k])
        );
    end

endmodule

// File: tb/tb_demux_1x16_buf.sv
// Directed self-checking bench for demux_1x16_buf (vector table plus corner sequences).
module tb_demux_1x16_buf;

    logic          clk;
    logic          clr;
    logic [31:0]   in_data;
    logic [3:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [511:0]  out_data;
    logic [15:0]   out_valid;
    logic [15:0]   out_ack;
    logic [4:0]    out_count;
    logic          in_bcast;

    int total;
    int bad;

    demux_1x16_buf #(.WIDTH(32), .N(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .out_count (out_count),
        .in_bcast  (in_bcast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
        logic        valid;
        logic [15:0] ack;
        logic        exp_ready;
        logic [15:0] exp_valid;
        logic [4:0]  exp_count;
        int          chk_slot;
        logic [31:0] exp_slot;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] slot(input int k);
        return out_data[k*32 +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check comb ready, then land 1 time unit past the edge.
    task automatic step(input string nm, input logic [3:0] sel, input logic [31:0] d,
                        input logic v, input logic [15:0] ack, input logic bc,
                        input logic exp_rdy);
        in_sel   = sel;
        in_data  = d;
        in_valid = v;
        out_ack  = ack;
        in_bcast = bc;
        #1;
        check({nm, "_ready"}, {31'b0, in_ready}, {31'b0, exp_rdy});
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        clr      = 1'b1;
        in_data  = '0;
        in_sel   = '0;
        in_valid = 1'b0;
        out_ack  = '0;
        in_bcast = 1'b0;

        //             sel   data          v     ack       rdy   exp_valid  cnt  slot exp_slot
        vecs[0] = '{4'd5,  32'hDEADBEEF, 1'b1, 16'h0000, 1'b1, 16'h0020, 5'd1, 5,  32'hDEADBEEF};
        vecs[1] = '{4'd5,  32'h00000000, 1'b0, 16'h0020, 1'b1, 16'h0000, 5'd0, 5,  32'hDEADBEEF};
        vecs[2] = '{4'd5,  32'h00000000, 1'b0, 16'h0020, 1'b1, 16'h0000, 5'd0, 5,  32'hDEADBEEF};
        vecs[3] = '{4'd7,  32'h00007777, 1'b1, 16'h0000, 1'b1, 16'h0080, 5'd1, 7,  32'h00007777};
        vecs[4] = '{4'd12, 32'h0000CCCC, 1'b1, 16'h0000, 1'b1, 16'h1080, 5'd2, 12, 32'h0000CCCC};
        vecs[5] = '{4'd0,  32'h00000001, 1'b1, 16'h1080, 1'b1, 16'h0001, 5'd1, 0,  32'h00000001};
        vecs[6] = '{4'd0,  32'h00000002, 1'b1, 16'h0001, 1'b1, 16'h0001, 5'd1, 0,  32'h00000002};
        vecs[7] = '{4'd0,  32'h00000000, 1'b0, 16'h0001, 1'b1, 16'h0000, 5'd0, 0,  32'h00000002};
        vecs[8] = '{4'd2,  32'h00000022, 1'b1, 16'h0000, 1'b1, 16'h0004, 5'd1, 2,  32'h00000022};
        vecs[9] = '{4'd9,  32'h00000099, 1'b1, 16'h0000, 1'b1, 16'h0204, 5'd2, 9,  32'h00000099};

        #12;
        check("rst_valid", {16'b0, out_valid}, 32'h0);
        check("rst_count", {27'b0, out_count}, 32'h0);
        check("rst_ready", {31'b0, in_ready}, 32'h1);
        check("rst_data5", slot(5), 32'h0);
        #4 clr = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].valid,
                 vecs[i].ack, 1'b0, vecs[i].exp_ready);
            check($sformatf("vec%0d_valid", i), {16'b0, out_valid}, {16'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_count", i), {27'b0, out_count}, {27'b0, vecs[i].exp_count});
            check($sformatf("vec%0d_slot", i), slot(vecs[i].chk_slot), vecs[i].exp_slot);
        end

        // Asynchronous clear with slots 2 and 9 full, observed before any edge.
        in_sel   = 4'd2;
        in_valid = 1'b0;
        out_ack  = '0;
        #1;
        check("pre_clr_ready", {31'b0, in_ready}, 32'h0);
        #1 clr = 1'b1;
        #1;
        check("clr_valid", {16'b0, out_valid}, 32'h0);
        check("clr_count", {27'b0, out_count}, 32'h0);
        check("clr_ready", {31'b0, in_ready}, 32'h1);
        check("clr_data2", slot(2), 32'h0);
        #3 clr = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure on a full slot, released by an ack on the fifth cycle.
        step("bp_fill", 4'd3, 32'h00003333, 1'b1, 16'h0000, 1'b0, 1'b1);
        check("bp_fill_valid", {16'b0, out_valid}, 32'h0008);
        for (int c = 0; c < 4; c++) begin
            step($sformatf("bp_hold%0d", c), 4'd3, 32'h00004444, 1'b1, 16'h0000, 1'b0, 1'b0);
            check($sformatf("bp_hold%0d_slot", c), slot(3), 32'h00003333);
            check($sformatf("bp_hold%0d_count", c), {27'b0, out_count}, 32'd1);
        end
        step("bp_rel", 4'd3, 32'h00004444, 1'b1, 16'h0008, 1'b0, 1'b1);
        check("bp_rel_slot", slot(3), 32'h00004444);
        check("bp_rel_valid", {16'b0, out_valid}, 32'h0008);
        check("bp_rel_count", {27'b0, out_count}, 32'd1);
        step("bp_drain", 4'd3, 32'h0, 1'b0, 16'h0008, 1'b0, 1'b1);
        check("bp_drain_count", {27'b0, out_count}, 32'd0);

        // Fill every slot back-to-back, then overflow attempt and drain.
        for (int i = 0; i < 16; i++) begin
            step($sformatf("fill%0d", i), 4'(i), 32'h100 + 32'(i), 1'b1, 16'h0000, 1'b0, 1'b1);
            check($sformatf("fill%0d_count", i), {27'b0, out_count}, 32'(i + 1));
        end
        check("fill_valid", {16'b0, out_valid}, 32'hFFFF);
        step("overflow", 4'd4, 32'hBAD0BAD0, 1'b1, 16'h0000, 1'b0, 1'b0);
        check("overflow_slot", slot(4), 32'h00000104);
        check("overflow_count", {27'b0, out_count}, 32'd16);
        step("drain", 4'd0, 32'h0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        check("drain_valid", {16'b0, out_valid}, 32'h0);
        check("drain_count", {27'b0, out_count}, 32'd0);
        step("ack_empty", 4'd4, 32'h0, 1'b0, 16'h0010, 1'b0, 1'b1);
        check("ack_empty_valid", {16'b0, out_valid}, 32'h0);
        check("ack_empty_count", {27'b0, out_count}, 32'd0);
        check("ack_empty_slot", slot(4), 32'h00000104);

`ifdef DEMUX_BCAST_EN
        step("bcast", 4'd3, 32'hA5A5A5A5, 1'b1, 16'h0000, 1'b1, 1'b1);
        check("bcast_valid", {16'b0, out_valid}, 32'hFFFF);
        check("bcast_count", {27'b0, out_count}, 32'd16);
        check("bcast_slot0", slot(0), 32'hA5A5A5A5);
        check("bcast_slot15", slot(15), 32'hA5A5A5A5);
        step("bcast_retry", 4'd3, 32'h5A5A5A5A, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        check("bcast_retry_valid", {16'b0, out_valid}, 32'h0001);
        check("bcast_retry_count", {27'b0, out_count}, 32'd1);
        check("bcast_retry_slot0", slot(0), 32'hA5A5A5A5);
        check("bcast_retry_slot7", slot(7), 32'hA5A5A5A5);
`else
        step("nobcast", 4'd6, 32'hA5A5A5A5, 1'b1, 16'h0000, 1'b1, 1'b1);
        check("nobcast_valid", {16'b0, out_valid}, 32'h0040);
        check("nobcast_count", {27'b0, out_count}, 32'd1);
        check("nobcast_slot6", slot(6), 32'hA5A5A5A5);
        check("nobcast_slot0", slot(0), 32'h00000100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
